// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: single-slot decode stage between fetch and execute.
// Holds one decoded instruction, tracks pending register writes in a
// 32-entry scoreboard, blocks RAW hazards, drops the slot on flush and
// counts fetch stall cycles.
module decode_issue_ctrl #(
   parameter bit WB_BYPASS = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic [31:0]      if_instruction,
   input  logic [31:0]      if_pc,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [31:0]      id_instruction,
   output logic [31:0]      id_pc,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic             flush,
   output logic [31:0]      sb_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic uses_rs1(input logic [31:0] ins);
      logic [2:0] f3;
      f3 = ins[14:12];
      case (ins[6:0])
         7'b0110011, 7'b0010011, 7'b0000011,
         7'b1100111, 7'b1100011, 7'b0100011: uses_rs1 = 1'b1;
         7'b1110011: uses_rs1 = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
         default:    uses_rs1 = 1'b0;
      endcase
   endfunction

   function automatic logic uses_rs2(input logic [31:0] ins);
      case (ins[6:0])
         7'b0110011, 7'b1100011, 7'b0100011: uses_rs2 = 1'b1;
         default:                            uses_rs2 = 1'b0;
      endcase
   endfunction

   // x0 destinations never count as writers.
   function automatic logic writes_rd(input logic [31:0] ins);
      logic w;
      case (ins[6:0])
         7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
         7'b1101111, 7'b0110111, 7'b0010111: w = 1'b1;
         7'b1110011: w = (ins[14:12] != 3'b000);
         default:    w = 1'b0;
      endcase
      writes_rd = w && (ins[11:7] != 5'd0);
   endfunction

   logic             id_valid_reg;
   logic [31:0]      id_instruction_reg;
   logic [31:0]      id_pc_reg;
   logic [31:0]      sb_busy_reg;
   logic [31:0]      sb_busy_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic             slot_wr;
   logic [4:0]       slot_rd;
   logic [1:0]       src_used;
   logic [4:0]       src_idx [2];
   logic [1:0]       src_haz;
   logic             hazard;
   logic             slot_free;
   logic             transfer_in;
   logic             issue;
   logic             stall_inc;

   assign slot_wr = writes_rd(id_instruction_reg);
   assign slot_rd = id_instruction_reg[11:7];

   assign src_used[0] = uses_rs1(if_instruction);
   assign src_used[1] = uses_rs2(if_instruction);
   assign src_idx[0]  = if_instruction[19:15];
   assign src_idx[1]  = if_instruction[24:20];

   // Per-source hazard. The writeback bypass only masks the scoreboard term:
   // a writer still sitting in the slot has not executed, so no writeback
   // can satisfy it.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         logic sb_term;
         logic slot_term;
         assign sb_term   = sb_busy_reg[src_idx[gi]] &&
                            !(WB_BYPASS && wb_valid && (wb_rd == src_idx[gi]));
         assign slot_term = id_valid_reg && slot_wr && (slot_rd == src_idx[gi]);
         assign src_haz[gi] = src_used[gi] && (src_idx[gi] != 5'd0) && (sb_term || slot_term);
      end
   endgenerate

   assign hazard      = |src_haz;
   assign slot_free   = !id_valid_reg || id_ready;
   assign if_ready    = slot_free && !hazard && !flush;
   assign transfer_in = if_valid && if_ready;
   assign issue       = id_valid_reg && id_ready && !flush;
   assign stall_inc   = if_valid && !if_ready && !flush;

   // Scoreboard next state per bit: an issuing writer sets, a writeback
   // clears; set takes priority because it belongs to the newer writer.
   generate
      for (gi = 0; gi < 32; gi++) begin : g_sb
         assign sb_busy_next[gi] =
            (issue && slot_wr && (slot_rd == 5'(gi))) ? 1'b1 :
            (wb_valid && (wb_rd == 5'(gi)) && (gi != 0)) ? 1'b0 :
            sb_busy_reg[gi];
      end
   endgenerate

   // Slot register: load on transfer-in, drop on flush or when execute
   // drains it; held unchanged under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid_reg       <= 1'b0;
         id_instruction_reg <= NOP;
         id_pc_reg          <= 32'd0;
      end else if (flush) begin
         id_valid_reg       <= 1'b0;
      end else if (transfer_in) begin
         id_valid_reg       <= 1'b1;
         id_instruction_reg <= if_instruction;
         id_pc_reg          <= if_pc;
      end else if (id_ready) begin
         id_valid_reg       <= 1'b0;
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk) begin
      if (rst) sb_busy_reg <= 32'd0;
      else     sb_busy_reg <= sb_busy_next;
   end

   // Saturating count of cycles where fetch offers but decode refuses.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt_reg <= '0;
      else if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   assign id_valid       = id_valid_reg;
   assign id_instruction = id_instruction_reg;
   assign id_pc          = id_pc_reg;
   assign sb_busy        = sb_busy_reg;
   assign stall_cnt      = stall_cnt_reg;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl (WB_BYPASS=1, CNT_W=4).
module tb_decode_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic [31:0] sb_busy;
   logic [3:0]  stall_cnt;

   int n_total = 0;
   int n_pass  = 0;

   decode_issue_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instruction(if_instruction), .if_pc(if_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instruction(id_instruction), .id_pc(id_pc),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
      .sb_busy(sb_busy), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h000, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
         $display("ok   %-16s = %h", tag, obs);
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; if_valid = 1'b0; if_instruction = 32'd0; if_pc = 32'd0;
      id_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
      tick(); tick();
      chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_id_instr", id_instruction, 32'h0000_0013);
      chk("rst_id_pc", id_pc, 32'd0);
      chk("rst_sb_busy", sb_busy, 32'd0);
      chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
      rst = 1'b0;
      tick();

      // 1. Stream of four independent addi
      for (int k = 0; k < 4; k++) begin
         if_valid = 1'b1;
         if_instruction = addi(5'(k + 1), 5'd0, 12'(k));
         if_pc = 32'h100 + 32'(4 * k);
         settle();
         chk("s1_if_ready", {31'd0, if_ready}, 32'd1);
         tick();
         chk("s1_id_valid", {31'd0, id_valid}, 32'd1);
         chk("s1_id_instr", id_instruction, addi(5'(k + 1), 5'd0, 12'(k)));
         chk("s1_id_pc", id_pc, 32'h100 + 32'(4 * k));
         chk("s1_sb_busy", sb_busy, (k == 0) ? 32'h0 : (k == 1) ? 32'h2 : (k == 2) ? 32'h6 : 32'hE);
      end
      if_valid = 1'b0;
      tick();
      chk("s1_sb_final", sb_busy, 32'h1E);
      chk("s1_drained", {31'd0, id_valid}, 32'd0);
      for (int r = 1; r <= 4; r++) begin
         wb_valid = 1'b1; wb_rd = 5'(r);
         tick();
      end
      wb_valid = 1'b0;
      chk("s1_sb_cleared", sb_busy, 32'h0);

      // 2. RAW hazard on x5 resolved by same-cycle writeback
      if_valid = 1'b1; if_instruction = addi(5'd5, 5'd0, 12'd1); if_pc = 32'h140;
      tick();
      if_instruction = add(5'd6, 5'd5, 5'd5); if_pc = 32'h144;
      settle();
      chk("s2_hold_slot", {31'd0, if_ready}, 32'd0);
      tick();
      chk("s2_sb_x5", sb_busy, 32'h20);
      chk("s2_hold_sb1", {31'd0, if_ready}, 32'd0);
      tick();
      chk("s2_hold_sb2", {31'd0, if_ready}, 32'd0);
      tick();
      chk("s2_stall_mid", {28'd0, stall_cnt}, 32'd3);
      wb_valid = 1'b1; wb_rd = 5'd5;
      settle();
      chk("s2_bypass_rdy", {31'd0, if_ready}, 32'd1);
      tick();
      chk("s2_id_instr", id_instruction, add(5'd6, 5'd5, 5'd5));
      chk("s2_sb_clear5", sb_busy, 32'h0);
      chk("s2_stall_cnt", {28'd0, stall_cnt}, 32'd3);
      if_valid = 1'b0; wb_valid = 1'b0;
      tick();
      chk("s2_sb_x6", sb_busy, 32'h40);
      wb_valid = 1'b1; wb_rd = 5'd6;
      tick();
      wb_valid = 1'b0;

      // 3. Backpressure with slot full
      id_ready = 1'b0;
      if_valid = 1'b1; if_instruction = addi(5'd10, 5'd0, 12'd7); if_pc = 32'h200;
      tick();
      if_instruction = addi(5'd11, 5'd0, 12'd8); if_pc = 32'h204;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("s3_if_ready", {31'd0, if_ready}, 32'd0);
         tick();
         chk("s3_hold_valid", {31'd0, id_valid}, 32'd1);
         chk("s3_hold_instr", id_instruction, addi(5'd10, 5'd0, 12'd7));
         chk("s3_hold_pc", id_pc, 32'h200);
      end
      chk("s3_stall_cnt", {28'd0, stall_cnt}, 32'd6);
      id_ready = 1'b1;
      settle();
      chk("s3_release_rdy", {31'd0, if_ready}, 32'd1);
      tick();
      chk("s3_next_instr", id_instruction, addi(5'd11, 5'd0, 12'd8));
      chk("s3_next_pc", id_pc, 32'h204);
      chk("s3_sb_x10", sb_busy, 32'h400);
      if_valid = 1'b0;
      tick();
      chk("s3_sb_x10_x11", sb_busy, 32'hC00);
      wb_valid = 1'b1; wb_rd = 5'd10; tick();
      wb_rd = 5'd11; tick();
      wb_valid = 1'b0;
      chk("s3_sb_cleared", sb_busy, 32'h0);

      // 4. Flush drops lw x7 and refuses the concurrent fetch
      if_valid = 1'b1; if_instruction = lw(5'd7, 5'd1); if_pc = 32'h300;
      tick();
      chk("s4_lw_loaded", id_instruction, lw(5'd7, 5'd1));
      flush = 1'b1; if_instruction = addi(5'd8, 5'd0, 12'd3); if_pc = 32'h304;
      settle();
      chk("s4_flush_rdy", {31'd0, if_ready}, 32'd0);
      tick();
      chk("s4_flush_valid", {31'd0, id_valid}, 32'd0);
      chk("s4_flush_sb", sb_busy, 32'h0);
      chk("s4_flush_stall", {28'd0, stall_cnt}, 32'd6);
      flush = 1'b0; if_valid = 1'b0;
      tick();
      chk("s4_not_taken", {31'd0, id_valid}, 32'd0);

      // 5. Set/clear collision on x9, then x0 writer and wb_rd=0
      if_valid = 1'b1; if_instruction = addi(5'd9, 5'd0, 12'd1); if_pc = 32'h340;
      tick();
      if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd9;
      tick();
      chk("s5_collision", sb_busy, 32'h200);
      wb_valid = 1'b0;
      if_valid = 1'b1; if_instruction = addi(5'd0, 5'd0, 12'd0); if_pc = 32'h344;
      tick();
      if_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd0;
      tick();
      chk("s5_x0_ignored", sb_busy, 32'h200);

      // 6. Saturating stall then reset mid-stall
      wb_rd = 5'd9;
      if_valid = 1'b1; if_instruction = addi(5'd8, 5'd0, 12'd2); if_pc = 32'h3F0;
      tick();
      wb_valid = 1'b0;
      if_instruction = addi(5'd12, 5'd0, 12'd4); if_pc = 32'h400;
      tick();
      chk("s6_sb_x8", sb_busy, 32'h100);
      id_ready = 1'b0;
      if_instruction = add(5'd13, 5'd8, 5'd8); if_pc = 32'h404;
      for (int c = 0; c < 9; c++) tick();
      chk("s6_stall_sat", {28'd0, stall_cnt}, 32'd15);
      for (int c = 0; c < 3; c++) tick();
      chk("s6_stall_hold", {28'd0, stall_cnt}, 32'd15);
      chk("s6_slot_full", {31'd0, id_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("s6_rst_valid", {31'd0, id_valid}, 32'd0);
      chk("s6_rst_instr", id_instruction, 32'h0000_0013);
      chk("s6_rst_pc", id_pc, 32'd0);
      chk("s6_rst_sb", sb_busy, 32'd0);
      chk("s6_rst_stall", {28'd0, stall_cnt}, 32'd0);
      rst = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
      wb_valid = 1'b1; wb_rd = 5'd8;
      tick();
      wb_valid = 1'b0;
      chk("s6_post_wb_sb", sb_busy, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
